// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage: opcode constants,
// instruction field positions, default widths and the field decoder.
// Optional feature macro used by decode_stage: DECODE_LOAD_USE_HAZARD_EN.
package decode_pkg;

   // Default widths
   localparam int DATA_W_DEF  = 32;
   localparam int ADDR_W_DEF  = 5;
   localparam int REG_CNT_DEF = 32;

   // Opcode constants
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   // Instruction field bit positions
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;

   // Decoded instruction fields held in the decode/execute latch
   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [5:0]  funct;
      logic [31:0] imm;
   } dec_fields_t;

   // Sign-extend a 16-bit immediate to 32 bits
   function automatic logic [31:0] sign_ext16(input logic [15:0] val);
      return {{16{val[15]}}, val};
   endfunction

   // Split a 32-bit instruction word into its fields
   function automatic dec_fields_t decode_fields(input logic [31:0] instr);
      dec_fields_t f;
      f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
      f.rs     = instr[RS_MSB:RS_LSB];
      f.rt     = instr[RT_MSB:RT_LSB];
      f.rd     = instr[RD_MSB:RD_LSB];
      f.funct  = instr[FUNCT_MSB:FUNCT_LSB];
      f.imm    = sign_ext16(instr[IMM_MSB:IMM_LSB]);
      return f;
   endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, register 0 hardwired to zero, whole array cleared on reset.
module register_file
   import decode_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_CNT = REG_CNT_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [ADDR_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o
);

   logic [DATA_W-1:0] mem_q [REG_CNT];

   // Storage array: cleared on reset, written on we_i except for register 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
      end else if (we_i && (waddr_i != {ADDR_W{1'b0}})) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read ports: register 0 always reads zero regardless of array contents
   always_comb begin
      rdata_a_o = {DATA_W{1'b0}};
      rdata_b_o = {DATA_W{1'b0}};
      if (raddr_a_i != {ADDR_W{1'b0}}) begin
         rdata_a_o = mem_q[raddr_a_i];
      end else begin
         rdata_a_o = {DATA_W{1'b0}};
      end
      if (raddr_b_i != {ADDR_W{1'b0}}) begin
         rdata_b_o = mem_q[raddr_b_i];
      end else begin
         rdata_b_o = {DATA_W{1'b0}};
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: splits the fetched instruction into fields,
// reads operands (with write-back bypass), sign-extends the immediate and
// registers everything into the decode/execute latch under flush/stall.
// Optional feature macro: DECODE_LOAD_USE_HAZARD_EN (load-use bubble
// insertion); when undefined, load-use hazards are handled outside.
module decode_stage
   import decode_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_CNT = REG_CNT_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
`ifdef DECODE_LOAD_USE_HAZARD_EN
   // Opcode that marks an instruction in the latch as a load
  ,parameter logic [5:0] LOAD_OPCODE = OP_LW
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr_in,
   input  logic [DATA_W-1:0] next_pc_in,
   input  logic              valid_in,
   input  logic              stall_in,
   input  logic              flush_in,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ready_out,
   output logic              valid_out,
   output logic [DATA_W-1:0] pc_out,
   output logic [5:0]        opcode_out,
   output logic [5:0]        funct_out,
   output logic [4:0]        rs_addr_out,
   output logic [4:0]        rt_addr_out,
   output logic [4:0]        rd_addr_out,
   output logic [DATA_W-1:0] rs_data_out,
   output logic [DATA_W-1:0] rt_data_out,
   output logic [31:0]       imm_out
);

   dec_fields_t       dec_s;
   logic [DATA_W-1:0] rf_rs_s;
   logic [DATA_W-1:0] rf_rt_s;
   logic [DATA_W-1:0] rs_byp_s;
   logic [DATA_W-1:0] rt_byp_s;
   logic              hazard_s;

   logic              valid_q,   valid_d;
   logic [DATA_W-1:0] pc_q,      pc_d;
   dec_fields_t       fields_q,  fields_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;

   assign dec_s = decode_fields(instr_in);

   register_file #(
      .DATA_W  (DATA_W),
      .REG_CNT (REG_CNT),
      .ADDR_W  (ADDR_W)
   ) u_register_file (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (wb_en),
      .waddr_i   (wb_addr),
      .wdata_i   (wb_data),
      .raddr_a_i (dec_s.rs),
      .rdata_a_o (rf_rs_s),
      .raddr_b_i (dec_s.rt),
      .rdata_b_o (rf_rt_s)
   );

   // Write-through bypass: a same-edge write to a nonzero source register wins
   always_comb begin
      rs_byp_s = rf_rs_s;
      rt_byp_s = rf_rt_s;
      if (wb_en && (wb_addr == dec_s.rs) && (dec_s.rs != 5'd0)) begin
         rs_byp_s = wb_data;
      end else begin
         rs_byp_s = rf_rs_s;
      end
      if (wb_en && (wb_addr == dec_s.rt) && (dec_s.rt != 5'd0)) begin
         rt_byp_s = wb_data;
      end else begin
         rt_byp_s = rf_rt_s;
      end
   end

`ifdef DECODE_LOAD_USE_HAZARD_EN
   // Load-use detection: latched load targets a source of the incoming instruction
   always_comb begin
      hazard_s = 1'b0;
      if (valid_q && valid_in && (fields_q.opcode == LOAD_OPCODE) &&
          (fields_q.rt != 5'd0) &&
          ((fields_q.rt == dec_s.rs) || (fields_q.rt == dec_s.rt))) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
   end
`else
   assign hazard_s = 1'b0;
`endif

   assign ready_out = !stall_in && !hazard_s;

   // Latch next-state: flush beats stall beats hazard bubble beats load
   always_comb begin
      valid_d   = valid_q;
      pc_d      = pc_q;
      fields_d  = fields_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      if (flush_in) begin
         valid_d = 1'b0;
      end else if (stall_in) begin
         valid_d = valid_q;
      end else if (hazard_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d   = valid_in;
         pc_d      = next_pc_in;
         fields_d  = dec_s;
         rs_data_d = rs_byp_s;
         rt_data_d = rt_byp_s;
      end
   end

   // Decode/execute latch registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= {DATA_W{1'b0}};
         fields_q  <= '{opcode: 6'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0,
                        funct: 6'd0, imm: 32'd0};
         rs_data_q <= {DATA_W{1'b0}};
         rt_data_q <= {DATA_W{1'b0}};
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         fields_q  <= fields_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
      end
   end

   assign valid_out   = valid_q;
   assign pc_out      = pc_q;
   assign opcode_out  = fields_q.opcode;
   assign funct_out   = fields_q.funct;
   assign rs_addr_out = fields_q.rs;
   assign rt_addr_out = fields_q.rt;
   assign rd_addr_out = fields_q.rd;
   assign rs_data_out = rs_data_q;
   assign rt_data_out = rt_data_q;
   assign imm_out     = fields_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with a behavioural latch/register model.
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr_in;
   logic [31:0] next_pc_in;
   logic        valid_in;
   logic        stall_in;
   logic        flush_in;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ready_out;
   logic        valid_out;
   logic [31:0] pc_out;
   logic [5:0]  opcode_out;
   logic [5:0]  funct_out;
   logic [4:0]  rs_addr_out;
   logic [4:0]  rt_addr_out;
   logic [4:0]  rd_addr_out;
   logic [31:0] rs_data_out;
   logic [31:0] rt_data_out;
   logic [31:0] imm_out;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] regs [32];
   logic        m_valid;
   logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
   logic [5:0]  m_op, m_funct;
   logic [4:0]  m_rs, m_rt, m_rd;

   decode_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_in    (instr_in),
      .next_pc_in  (next_pc_in),
      .valid_in    (valid_in),
      .stall_in    (stall_in),
      .flush_in    (flush_in),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .ready_out   (ready_out),
      .valid_out   (valid_out),
      .pc_out      (pc_out),
      .opcode_out  (opcode_out),
      .funct_out   (funct_out),
      .rs_addr_out (rs_addr_out),
      .rt_addr_out (rt_addr_out),
      .rd_addr_out (rd_addr_out),
      .rs_data_out (rs_data_out),
      .rt_data_out (rt_data_out),
      .imm_out     (imm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      m_valid = 1'b0; m_pc = 32'd0; m_rsd = 32'd0; m_rtd = 32'd0; m_imm = 32'd0;
      m_op = 6'd0; m_funct = 6'd0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
   endtask

   task automatic compare_all();
      chk("valid_out",   {31'd0, valid_out},   {31'd0, m_valid});
      chk("pc_out",      pc_out,               m_pc);
      chk("opcode_out",  {26'd0, opcode_out},  {26'd0, m_op});
      chk("funct_out",   {26'd0, funct_out},   {26'd0, m_funct});
      chk("rs_addr_out", {27'd0, rs_addr_out}, {27'd0, m_rs});
      chk("rt_addr_out", {27'd0, rt_addr_out}, {27'd0, m_rt});
      chk("rd_addr_out", {27'd0, rd_addr_out}, {27'd0, m_rd});
      chk("rs_data_out", rs_data_out,          m_rsd);
      chk("rt_data_out", rt_data_out,          m_rtd);
      chk("imm_out",     imm_out,              m_imm);
   endtask

   // Operand value seen by an instruction: r0 is zero, same-edge write wins
   function automatic logic [31:0] operand(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_en && wb_addr == a) return wb_data;
      return regs[a];
   endfunction

   // One clock: predict from current inputs, check ready, clock, check latch
   task automatic step();
      logic        hz;
      logic [4:0]  s, t;
      logic [15:0] im;
      #1;
      s  = instr_in[25:21];
      t  = instr_in[20:16];
      im = instr_in[15:0];
      hz = 1'b0;
`ifdef DECODE_LOAD_USE_HAZARD_EN
      hz = m_valid && valid_in && (m_op == 6'h23) && (m_rt != 5'd0) &&
           ((m_rt == s) || (m_rt == t));
`endif
      chk("ready_out", {31'd0, ready_out}, {31'd0, (!stall_in && !hz)});
      if (flush_in) m_valid = 1'b0;
      else if (stall_in) m_valid = m_valid;
      else if (hz) m_valid = 1'b0;
      else begin
         m_valid = valid_in;
         m_pc    = next_pc_in;
         m_op    = instr_in[31:26];
         m_funct = instr_in[5:0];
         m_rs    = s;
         m_rt    = t;
         m_rd    = instr_in[15:11];
         m_rsd   = operand(s);
         m_rtd   = operand(t);
         m_imm   = 32'($signed(im));
      end
      if (wb_en && wb_addr != 5'd0) regs[wb_addr] = wb_data;
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                        input logic st, input logic fl);
      instr_in = ins; next_pc_in = pc; valid_in = v; stall_in = st; flush_in = fl;
   endtask

   task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
      wb_en = en; wb_addr = a; wb_data = d;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      wb(1'b0, 5'd0, 32'd0);
      model_reset();
      #12;
      compare_all();
      chk("reset ready_out", {31'd0, ready_out}, 32'd1);
      chk("reset valid_out", {31'd0, valid_out}, 32'd0);
      rst_n = 1'b1;

      // Write r5 during a bubble, then add r4,r5,r6
      drive(32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
      wb(1'b1, 5'd5, 32'hDEAD_BEEF);
      step();
      chk("bubble valid_out", {31'd0, valid_out}, 32'd0);
      drive(32'h00A6_2020, 32'h0000_0008, 1'b1, 1'b0, 1'b0);
      wb(1'b0, 5'd0, 32'd0);
      step();
      chk("add rs_data", rs_data_out, 32'hDEAD_BEEF);
      chk("add rd_addr", {27'd0, rd_addr_out}, 32'd4);
      chk("add funct",   {26'd0, funct_out}, 32'h20);
      chk("add valid",   {31'd0, valid_out}, 32'd1);

      // Same-edge write to r6 is bypassed into rt operand
      drive(32'h00A6_2020, 32'h0000_000C, 1'b1, 1'b0, 1'b0);
      wb(1'b1, 5'd6, 32'h1234_5678);
      step();
      chk("bypass rt_data", rt_data_out, 32'h1234_5678);

      // Writes to r0 are ignored, both bypassed and stored
      drive(32'h0000_2020, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
      wb(1'b1, 5'd0, 32'hFFFF_FFFF);
      step();
      chk("r0 bypass", rs_data_out, 32'd0);
      wb(1'b0, 5'd0, 32'd0);
      step();
      chk("r0 read", rt_data_out, 32'd0);

      // Immediate sign extension
      drive(32'h2002_FFFC, 32'h0000_0014, 1'b1, 1'b0, 1'b0);
      step();
      chk("imm negative", imm_out, 32'hFFFF_FFFC);
      drive(32'h2002_7FFF, 32'h0000_0018, 1'b1, 1'b0, 1'b0);
      step();
      chk("imm positive", imm_out, 32'h0000_7FFF);

      // Stall for three cycles with changing input; write-back continues
      for (int i = 0; i < 3; i++) begin
         drive(32'h0128_5022 + 32'(i), 32'h0000_0100 + 32'(i * 4), 1'b1, 1'b1, 1'b0);
         wb(1'b1, 5'd7, 32'hA5A5_0000 + 32'(i));
         step();
         chk("stall imm held", imm_out, 32'h0000_7FFF);
      end
      wb(1'b0, 5'd0, 32'd0);
      drive(32'h00E0_0000, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
      step();
      chk("write during stall", rs_data_out, 32'hA5A5_0002);

      // Flush with stall, and flush alone
      drive(32'h00A6_2020, 32'h0000_0204, 1'b1, 1'b1, 1'b1);
      step();
      chk("flush+stall valid", {31'd0, valid_out}, 32'd0);
      drive(32'h00A6_2020, 32'h0000_0208, 1'b1, 1'b0, 1'b0);
      step();
      drive(32'h00C5_3820, 32'h0000_020C, 1'b1, 1'b0, 1'b1);
      step();
      chk("flush valid", {31'd0, valid_out}, 32'd0);
      chk("flush pc held", pc_out, 32'h0000_0208);

      // Bubble loads fields with valid_out low
      drive(32'h00C5_3820, 32'h0000_0210, 1'b0, 1'b0, 1'b0);
      step();
      chk("bubble rd", {27'd0, rd_addr_out}, 32'd7);

      // Asynchronous reset between clock edges
      drive(32'h00A6_2020, 32'h0000_0214, 1'b1, 1'b0, 1'b0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("async reset pc", pc_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(32'h00A6_2020, 32'h0000_0300, 1'b1, 1'b0, 1'b0);
      step();
      chk("rf cleared r5", rs_data_out, 32'd0);

      // Load-use: lw r8,0(r1) then add r9,r8,r2
      drive(32'h8C28_0000, 32'h0000_0304, 1'b1, 1'b0, 1'b0);
      step();
      drive(32'h0102_4820, 32'h0000_0308, 1'b1, 1'b0, 1'b0);
      step();
`ifdef DECODE_LOAD_USE_HAZARD_EN
      chk("load-use bubble", {31'd0, valid_out}, 32'd0);
      chk("load-use pc held", pc_out, 32'h0000_0304);
      step();
`endif
      chk("add after load valid", {31'd0, valid_out}, 32'd1);
      chk("add after load rd", {27'd0, rd_addr_out}, 32'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction decode stage, directly downstream of the fetch stage. It consumes the latched 32-bit instruction and next-PC, reads two operands from an internal 32x32 register file, and sign-extends the 16-bit immediate. It registers all decoded fields into a decode/execute pipeline latch with valid/stall/flush control. A write-back port from the last stage updates the register file.

Parameters:
DATA_W, 32, register and PC data width
REG_CNT, 32, number of architectural registers
ADDR_W, 5, register address width (log2 REG_CNT)
LOAD_OPCODE, 6'h23, opcode treated as a load by the hazard logic

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_in  in  32  instruction from the fetch latch
next_pc_in  in  32  PC+4 from the fetch latch
valid_in  in  1  instr_in/next_pc_in carry a real instruction
stall_in  in  1  downstream cannot accept; hold the output latch
flush_in  in  1  kill the instruction being latched (branch taken)
wb_en  in  1  register-file write enable
wb_addr  in  5  write-back register address
wb_data  in  32  write-back data
ready_out  out  1  decode can accept a new instruction this cycle
valid_out  out  1  output latch holds a valid instruction
pc_out  out  32  latched next_pc_in
opcode_out  out  6  instr[31:26]
funct_out  out  6  instr[5:0]
rs_addr_out / rt_addr_out / rd_addr_out  out  5 each  instr[25:21] / [20:16] / [15:11]
rs_data_out / rt_data_out  out  32 each  register operands
imm_out  out  32  sign-extended instr[15:0]

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, valid_out 0, ready_out 1. All registers in the register file are cleared to 0.
- Latency: one cycle. Fields decoded from instr_in at edge N appear on the outputs after edge N.
- Priority at each rising edge: flush_in > stall_in > load.
  - flush_in=1: valid_out<=0; data fields are don't-care but are held.
  - stall_in=1 (no flush): every output register holds its value.
  - Otherwise: all fields are loaded, and valid_out<=valid_in.
- ready_out = !stall_in && !hazard. The hazard term exists only under the optional feature.
- Register file:
  - Combinational read.
  - Synchronous write on wb_en, applied at the same edge as the latch update.
  - Register 0 always reads 0; writes to it are ignored.
- Write-through bypass: if wb_en and wb_addr==rs (or rt) and the address is nonzero, the latched operand takes wb_data, not the stale array value.
- imm_out = {{16{instr[15]}}, instr[15:0]}.
- valid_in=0 with no stall: a bubble is latched (valid_out=0). Fields still load; downstream ignores them.
- Write-back continues during stall and flush. Writes never depend on pipeline control.

Optional Feature:
Macro DECODE_LOAD_USE_HAZARD_EN.
- Defined: hazard = valid_out && opcode_out==LOAD_OPCODE && rt_addr_out!=0 && (rt_addr_out==instr_in rs || rt_addr_out==instr_in rt) && valid_in.
  - When hazard=1 and there is no stall or flush, the edge loads a bubble: valid_out<=0, and pc_out and fields are held.
  - ready_out drops for that cycle, so fetch holds instr_in.
  - On the next cycle the bubble has cleared the comparison, and the instruction is accepted.
- Undefined: hazard tied to 0, and ready_out = !stall_in. Load-use hazards are handled externally.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OP_RTYPE 6'h00, OP_LW 6'h23, OP_SW 6'h2B, OP_BEQ 6'h04)
  - instruction field bit positions
  - DATA_W/ADDR_W defaults
- One sub-module, register_file: 2 read ports, 1 write port, r0 hardwired, reset clear. Bypass muxing stays in decode_stage.

Test Plan:
- Reset then wb writes r5=32'hDEADBEEF; instr_in=32'h00A62020 (add r4,r5,r6), valid_in=1 -> next cycle rs_data_out=DEADBEEF, rd_addr_out=4, funct_out=6'h20, valid_out=1.
- Same-cycle write/read: wb_en r6=32'h12345678 while instr_in reads r6 -> rt_data_out=12345678 (bypass). Write r0=FFFFFFFF -> subsequent read of r0 returns 0.
- instr_in=32'h2002FFFC (addi imm -4) -> imm_out=32'hFFFFFFFC. Immediate 16'h7FFF -> imm_out=32'h00007FFF.
- stall_in=1 for 3 cycles while instr_in changes -> outputs unchanged and ready_out=0. flush_in and stall_in together -> valid_out=0.
- Assert rst_n low mid-stream, between clock edges -> outputs 0 immediately, without waiting for an edge; register file reads 0 after release.
- (Feature on) lw r8,0(r1) followed by add r9,r8,r2 -> one bubble cycle (valid_out=0, ready_out=0), then add is latched with valid_out=1. With the macro undefined, there is no bubble.
